// File: rtl/tmr_resync_pkg.sv
// Shared types for the TMR resync controller.
// Holds the controller FSM state encoding and the replica index type.
// No ports; imported by tmr_resync_ctrl.
package tmr_resync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_FAILED = 2'd2
  } state_e;

  typedef logic [1:0] replica_id_t;

endpackage

// File: rtl/tmr_err_cnt.sv
// Saturating up/down error counter for one TMR replica.
// Ports: clk, rst_n (async active-low), inc/dec/clr/hold controls, cnt value.
// Priority clr > hold > inc > dec; inc saturates at all-ones, dec stops at zero.
module tmr_err_cnt #(
  parameter int Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  input  logic             hold,
  output logic [Width-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + Width'(1);
    end else if (!inc && dec && (cnt != '0)) begin
      cnt <= cnt - Width'(1);
    end
  end

endmodule

// File: rtl/tmr_resync_ctrl.sv
// TMR resync controller: counts per-replica mismatches, requests a resync of
// the first replica to reach Threshold, and latches a fatal state on
// multi-replica faults. Ports: clk_i/rst_ni, err_i flags, resync req/id/ack
// handshake, fatal_o/fatal_clr_i, per-replica and total counters, state_o.
module tmr_resync_ctrl
  import tmr_resync_pkg::*;
#(
  parameter int Threshold   = 3,
  parameter int CntWidth    = 4,
  parameter int DecayCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [2:0]            err_i,
  output logic                  resync_req_o,
  output logic [1:0]            resync_id_o,
  input  logic                  resync_ack_i,
  output logic                  fatal_o,
  input  logic                  fatal_clr_i,
  output logic [3*CntWidth-1:0] err_cnt_o,
  output logic [15:0]           total_err_o,
  output logic [1:0]            state_o
);

  localparam int CleanW = (DecayCycles > 1) ? $clog2(DecayCycles) : 1;
  localparam logic [CleanW-1:0] CleanLast =
      CleanW'((DecayCycles > 0) ? DecayCycles - 1 : 0);

  state_e              state_q, state_d;
  replica_id_t         id_q, id_d;
  logic [CntWidth-1:0] cnt [3];
  logic [CleanW-1:0]   clean_q;
  logic [15:0]         total_q;
  logic [2:0]          hit, inc, clr;
  logic                multi, other_hit, ack_ok, fclr_ok, hold, decay_tick;

  // Decisions use the registered counter values, which gives the one-cycle
  // gap between the threshold-reaching pulse and the request.
  always_comb begin
    for (int k = 0; k < 3; k++) hit[k] = (cnt[k] >= CntWidth'(Threshold));
  end

  assign multi     = (err_i[0] & err_i[1]) | (err_i[0] & err_i[2]) | (err_i[1] & err_i[2]);
  assign other_hit = |(hit & ~(3'b001 << id_q));

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (multi) begin
          state_d = ST_FAILED;
        end else if (|hit) begin
          state_d = ST_REQ;
          id_d    = hit[0] ? 2'd0 : (hit[1] ? 2'd1 : 2'd2);
        end
      end
      ST_REQ: begin
        // A fatal trigger outranks a coincident acknowledge.
        if (multi || other_hit) state_d = ST_FAILED;
        else if (resync_ack_i)  state_d = ST_IDLE;
      end
      ST_FAILED: begin
        // A fresh trigger outranks a coincident clear.
        if (!multi && fatal_clr_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ack_ok  = (state_q == ST_REQ) && resync_ack_i && !multi && !other_hit;
  assign fclr_ok = (state_q == ST_FAILED) && fatal_clr_i && !multi;
  assign hold    = (state_q == ST_FAILED);

  // Decay only ever fires on an error-free cycle, so it never collides with
  // an increment on the same counter.
  assign decay_tick = (DecayCycles != 0) && (err_i == 3'b000) && !hold &&
                      (clean_q == CleanLast);

  for (genvar k = 0; k < 3; k++) begin : g_cnt
    assign inc[k] = err_i[k] && !hold && !((state_q == ST_REQ) && (id_q == replica_id_t'(k)));
    assign clr[k] = fclr_ok || (ack_ok && (id_q == replica_id_t'(k)));

    tmr_err_cnt #(.Width(CntWidth)) u_cnt (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .inc   (inc[k]),
      .dec   (decay_tick),
      .clr   (clr[k]),
      .hold  (hold),
      .cnt   (cnt[k])
    );

    assign err_cnt_o[k*CntWidth +: CntWidth] = cnt[k];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      clean_q <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      if (fclr_ok) begin
        clean_q <= '0;
      end else if (!hold) begin
        if ((err_i != 3'b000) || decay_tick || (DecayCycles == 0)) clean_q <= '0;
        else                                                      clean_q <= clean_q + CleanW'(1);
      end
      if ((err_i != 3'b000) && (total_q != 16'hFFFF)) total_q <= total_q + 16'd1;
    end
  end

  assign resync_req_o = (state_q == ST_REQ);
  assign resync_id_o  = id_q;
  assign fatal_o      = (state_q == ST_FAILED);
  assign total_err_o  = total_q;
  assign state_o      = state_q;

endmodule

// File: doc/tmr_resync_ctrl.md
TMR_RESYNC_CTRL -- requirements
Module: tmr_resync_ctrl

Interface
REQ-001 Parameter Threshold, default 3, SHALL set the per-replica error count that triggers a resync request (range 1..2^CntWidth-1).
REQ-002 Parameter CntWidth, default 4, SHALL set the width of each per-replica saturating error counter.
REQ-003 Parameter DecayCycles, default 1024, SHALL set the number of consecutive error-free cycles per counter decrement; 0 disables decay.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 err_i  in  3  per-replica mismatch flags from a TMR voter-detect stage, bit k = replica k.
REQ-008 resync_req_o  out  1  resync request for one replica.
REQ-009 resync_id_o  out  2  replica index (0..2) being resynced, valid while resync_req_o=1.
REQ-010 resync_ack_i  in  1  resync completed by the requester's target.
REQ-011 fatal_o  out  1  sticky unrecoverable-fault flag.
REQ-012 fatal_clr_i  in  1  clears fatal state.
REQ-013 err_cnt_o  out  3*CntWidth  per-replica counters, replica k at bits [k*CntWidth +: CntWidth].
REQ-014 total_err_o  out  16  saturating count of cycles with err_i != 0.
REQ-015 state_o  out  2  FSM state: IDLE=0, REQ=1, FAILED=2.

Function
REQ-016 Each cycle with err_i[k]=1 SHALL increment cnt[k] by 1 at the next edge, saturating at 2^CntWidth-1, except as in REQ-021 and REQ-025.
REQ-017 total_err_o SHALL increment by 1 per cycle with err_i != 0, saturating at 16'hFFFF, never cleared except by reset.
REQ-018 Decay: a clean-cycle counter SHALL increment on each cycle with err_i=0 and clear on any error; on reaching DecayCycles, every nonzero cnt[k] SHALL decrement by 1 and the clean counter SHALL restart at 0.
REQ-019 IDLE: if any cnt[k] >= Threshold (registered value), the FSM SHALL enter REQ at the next edge with resync_id_o = lowest such k, and resync_req_o = 1.
REQ-020 Latency: the err_i pulse that brings cnt[k] to Threshold at edge n SHALL produce resync_req_o=1 after edge n+1.
REQ-021 REQ: resync_req_o and resync_id_o SHALL stay stable until resync_ack_i=1 is sampled; err_i[resync_id_o] SHALL be ignored for counting.
REQ-022 On the edge sampling resync_ack_i=1 in REQ, cnt[resync_id_o] SHALL clear to 0, resync_req_o SHALL drop, and the FSM SHALL return to IDLE.
REQ-023 resync_ack_i while not in REQ SHALL be ignored.
REQ-024 Fatal triggers: err_i with two or more bits set in one cycle, or a replica other than resync_id_o reaching Threshold while in REQ; the FSM SHALL enter FAILED at the next edge, setting fatal_o=1 and dropping resync_req_o.
REQ-025 FAILED: counters SHALL hold (no increment, no decay); fatal_o SHALL remain 1 until fatal_clr_i=1 is sampled, whereupon all cnt clear, clean counter clears, FSM goes IDLE.
REQ-026 Simultaneous fatal trigger and fatal_clr_i on the same edge: the trigger SHALL win (stay/enter FAILED).
REQ-027 Simultaneous resync_ack_i and fatal trigger in REQ: the fatal trigger SHALL win; counter not cleared.
REQ-028 Simultaneous increment and decay on one counter SHALL be impossible by construction (decay only on clean cycles).

Reset
REQ-029 On rst_ni=0 all counters, total_err_o, fatal_o, resync_req_o SHALL be 0, resync_id_o SHALL be 0, state_o SHALL be IDLE, asynchronously.
REQ-030 Reset asserted mid-REQ SHALL drop resync_req_o immediately; no pending ack is remembered.

Structure
REQ-031 Package tmr_resync_pkg SHALL hold the FSM state enum and the 2-bit replica-id typedef.
REQ-032 Sub-module tmr_err_cnt (saturating up/down counter with inc, dec, clr, hold) SHALL be instantiated three times.

Verification (Threshold=3, CntWidth=4, DecayCycles=16)
REQ-033 err_i=3'b010 for 3 single cycles -> cnt[1]=3, resync_req_o=1, resync_id_o=1 one cycle later; ack -> cnt[1]=0, state IDLE.
REQ-034 err_i=3'b001 twice, then 16 clean cycles -> cnt[0] decrements 2->1; 16 more -> 0; no request.
REQ-035 err_i=3'b011 for one cycle -> fatal_o=1, state FAILED; fatal_clr_i pulse -> all counters 0, IDLE, total_err_o=1.
REQ-036 During REQ for replica 2, err_i=3'b100 repeatedly -> cnt[2] unchanged; err_i=3'b001 x3 -> FAILED, resync_req_o=0.
REQ-037 20 err pulses on replica 0 held in FAILED -> cnt[0] frozen; reset mid-REQ -> all outputs 0 immediately; total_err_o saturation at 16'hFFFF after 65535+ error cycles.
